// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller.
package vend_pkg;

   // Coin values in nickel units
   localparam int unsigned COIN_NICKEL  = 1;
   localparam int unsigned COIN_DIME    = 2;
   localparam int unsigned COIN_QUARTER = 5;

   // Widest price table the extract helper accepts
   localparam int unsigned PRICE_VEC_W = 256;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      CHANGE   = 2'd2
   } vend_state_e;

   // Pull one price field out of a packed price table (item 0 in the LSBs)
   function automatic logic [31:0] price_at(
      input logic [PRICE_VEC_W-1:0] prices,
      input int unsigned            idx,
      input int unsigned            width
   );
      logic [PRICE_VEC_W-1:0] field;
      logic [PRICE_VEC_W-1:0] mask;
      mask  = (PRICE_VEC_W'(1) << width) - PRICE_VEC_W'(1);
      field = (prices >> (idx * width)) & mask;
      return field[31:0];
   endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with reload, decrement-on-vend and empty flags.
module vend_stock_bank
   import vend_pkg::*;
#(
   parameter int unsigned NUM_ITEMS  = 4,
   parameter int unsigned STOCK_W    = 4,
   parameter int unsigned STOCK_INIT = 2,
   parameter int unsigned SEL_W      = 2
)(
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 load,
   input  logic [SEL_W-1:0]     load_item,
   input  logic                 dec,
   input  logic [SEL_W-1:0]     dec_item,
   output logic [NUM_ITEMS-1:0] empty
);

   logic [STOCK_W-1:0] stock [NUM_ITEMS];

   // Stock counters: reset and reload to STOCK_INIT, count down on a vend
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock[i] <= STOCK_W'(STOCK_INIT);
         end
      end else begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            if (load && (32'(load_item) == 32'(i))) begin
               stock[i] <= STOCK_W'(STOCK_INIT);
            end else if (dec && (32'(dec_item) == 32'(i)) && (stock[i] != '0)) begin
               stock[i] <= stock[i] - STOCK_W'(1);
            end
         end
      end
   end

   // Empty flags used to refuse a selection
   always_comb begin
      empty = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         empty[i] = (stock[i] == '0);
      end
   end

endmodule

// File: rtl/vend_multi_item_ctrl.sv
// Multi-item vending controller: shared credit, per-item price and stock,
// nickel-at-a-time change and refund.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | accept coins, selection, cancel and restock
// DISPENSE | one-cycle vend pulse for the latched item
// CHANGE   | one nickel out per cycle until credit is 0
module vend_multi_item_ctrl #(
   parameter int unsigned NUM_ITEMS  = 4,
   parameter int unsigned CREDIT_W   = 8,
   parameter int unsigned MAX_CREDIT = 40,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {8'd7, 8'd5, 8'd4, 8'd3},
   parameter int unsigned STOCK_W    = 4,
   parameter int unsigned STOCK_INIT = 2,
   localparam int unsigned SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
)(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                nickel_in,
   input  logic                dime_in,
   input  logic                quarter_in,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel_item,
   input  logic                cancel,
   input  logic                restock,
   output logic                dispense,
   output logic [SEL_W-1:0]    dispense_item,
   output logic                nickel_out,
   output logic                coin_reject,
   output logic                sel_nack,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit
);

   import vend_pkg::*;

   vend_state_e         state, state_nxt;
   logic [CREDIT_W-1:0] credit_q, credit_nxt;
   logic [SEL_W-1:0]    item_q, item_nxt;
   logic                coin_reject_q, coin_reject_nxt;
   logic                sel_nack_q, sel_nack_nxt;

   logic [NUM_ITEMS-1:0] empty;
   logic                 item_empty;
   logic                 item_ok;
   logic [CREDIT_W-1:0]  price;
   logic                 stock_load, stock_dec;

   logic [CREDIT_W:0]    coin_val;
   logic [1:0]           coin_cnt;
   logic                 coin_any;
   logic [CREDIT_W:0]    base;
   logic [CREDIT_W:0]    sum;
   logic                 coin_fits;
   logic                 cancel_eff;
   logic                 sel_ok;

   vend_stock_bank #(
      .NUM_ITEMS  (NUM_ITEMS),
      .STOCK_W    (STOCK_W),
      .STOCK_INIT (STOCK_INIT),
      .SEL_W      (SEL_W)
   ) u_stock (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (stock_load),
      .load_item (sel_item),
      .dec       (stock_dec),
      .dec_item  (sel_item),
      .empty     (empty)
   );

   // Selected item lookup: range, price and stock state
   always_comb begin
      item_ok    = (32'(sel_item) < 32'(NUM_ITEMS));
      price      = CREDIT_W'(price_at(PRICE_VEC_W'(ITEM_PRICES), 32'(sel_item), CREDIT_W));
      item_empty = 1'b1;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (32'(sel_item) == 32'(i)) begin
            item_empty = empty[i];
         end
      end
   end

   // Coin decode: highest-value coin wins, the rest are rejected
   always_comb begin
      coin_val = '0;
      if (quarter_in) begin
         coin_val = (CREDIT_W+1)'(COIN_QUARTER);
      end else if (dime_in) begin
         coin_val = (CREDIT_W+1)'(COIN_DIME);
      end else if (nickel_in) begin
         coin_val = (CREDIT_W+1)'(COIN_NICKEL);
      end
      coin_cnt = 2'(nickel_in) + 2'(dime_in) + 2'(quarter_in);
      coin_any = nickel_in | dime_in | quarter_in;
   end

   // Next-state, credit and pulse decisions
   always_comb begin
      state_nxt       = state;
      credit_nxt      = credit_q;
      item_nxt        = item_q;
      coin_reject_nxt = coin_any;
      sel_nack_nxt    = 1'b0;
      stock_load      = 1'b0;
      stock_dec       = 1'b0;
      cancel_eff      = 1'b0;
      sel_ok          = 1'b0;
      base            = {1'b0, credit_q};
      sum             = base;
      coin_fits       = 1'b0;

      case (state)
         IDLE: begin
            cancel_eff = cancel && (credit_q != '0);
            sel_ok     = sel_valid && !restock && !cancel_eff && item_ok &&
                         (credit_q >= price) && !item_empty;
            if (sel_ok) begin
               base = {1'b0, credit_q - price};
            end
            // A coin is credited whole or not at all
            sum       = base + coin_val;
            coin_fits = coin_any && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
            credit_nxt      = coin_fits ? sum[CREDIT_W-1:0] : base[CREDIT_W-1:0];
            coin_reject_nxt = (coin_cnt > (coin_fits ? 2'd1 : 2'd0));
            sel_nack_nxt    = sel_valid && !cancel_eff && !sel_ok;
            stock_load      = restock && !cancel_eff && item_ok;
            stock_dec       = sel_ok;
            if (cancel_eff) begin
               state_nxt = CHANGE;
            end else if (sel_ok) begin
               state_nxt = DISPENSE;
               item_nxt  = sel_item;
            end
         end
         DISPENSE: begin
            state_nxt = (credit_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            if (credit_q != '0) begin
               credit_nxt = credit_q - CREDIT_W'(1);
            end
            if (credit_q <= CREDIT_W'(1)) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, credit, latched item and registered pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         credit_q      <= '0;
         item_q        <= '0;
         coin_reject_q <= 1'b0;
         sel_nack_q    <= 1'b0;
      end else begin
         state         <= state_nxt;
         credit_q      <= credit_nxt;
         item_q        <= item_nxt;
         coin_reject_q <= coin_reject_nxt;
         sel_nack_q    <= sel_nack_nxt;
      end
   end

   assign dispense      = (state == DISPENSE);
   assign dispense_item = dispense ? item_q : '0;
   assign nickel_out    = (state == CHANGE);
   assign busy          = (state != IDLE);
   assign coin_reject   = coin_reject_q;
   assign sel_nack      = sel_nack_q;
   assign credit        = credit_q;

endmodule
